// File: rtl/acc_cpu_pkg.sv
// Shared opcode, state and width definitions for the accumulator CPU core.
// Optional rotate opcodes (ROL/ROR) are enabled by the ACC_CPU_ROTATE_EN macro in the ALU.
package acc_cpu_pkg;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'h9;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'hA;
  localparam logic [OPC_W-1:0] OP_ADDM  = 4'hB;
  localparam logic [OPC_W-1:0] OP_ROL   = 4'hC;
  localparam logic [OPC_W-1:0] OP_ROR   = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;
endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: result, carry/shift-out and accumulator write enable per opcode.
// ROL/ROR exist only when ACC_CPU_ROTATE_EN is defined; otherwise C-F are NOPs.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              writes_acc
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of the difference is the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result     = a;
    carry      = 1'b0;
    writes_acc = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDM: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      OP_SUB:          begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      OP_LOAD, OP_LDI: result = b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_NOT:          result = ~a;
      OP_SHL:          begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
      OP_SHR:          begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0];        end
`ifdef ACC_CPU_ROTATE_EN
      OP_ROL:          begin result = {a[DATA_W-2:0], a[DATA_W-1]}; carry = a[DATA_W-1]; end
      OP_ROR:          begin result = {a[0], a[DATA_W-1:1]};        carry = a[0];        end
`endif
      default:         writes_acc = 1'b0;
    endcase
  end
endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: IDLE -> EXEC -> WB per accepted op, result strobe in WB.
// Rotate opcodes are selected by ACC_CPU_ROTATE_EN (see acc_cpu_alu).
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] acc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [OPC_W-1:0]    opc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   alu_b, alu_res;
  logic                alu_c, alu_wr, xfer;

  assign op_ready  = (state_q == ST_IDLE) && ena;
  assign xfer      = op_valid && op_ready;
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_WB);
  assign acc_out   = acc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;

  assign alu_b = ((opc_q == OP_LOAD) || (opc_q == OP_ADDM)) ? mem_q[addr_q] : imm_q;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode     (opc_q),
    .a          (acc_q),
    .b          (alu_b),
    .result     (alu_res),
    .carry      (alu_c),
    .writes_acc (alu_wr)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: if (xfer) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WB;
        if (alu_wr) begin
          acc_d = alu_res;
          z_d   = (alu_res == '0);
          c_d   = alu_c;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Acc/flags become visible with res_valid; the memory write lands at the end of WB,
  // so a reset anywhere inside the op leaves memory untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      addr_q  <= '0;
      imm_q   <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (xfer) begin
        opc_q  <= opcode;
        addr_q <= op_addr;
        imm_q  <= op_data;
      end
      if ((state_q == ST_WB) && (opc_q == OP_STORE)) mem_q[addr_q] <= acc_q;
    end
  end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed self-checking bench for acc_cpu_core (DATA_W=8, ADDR_W=4).
module tb_acc_cpu_core;
  logic       clk = 1'b0;
  logic       rst_n, ena, op_valid, op_ready;
  logic [3:0] opcode, op_addr;
  logic [7:0] op_data, acc_out;
  logic       res_valid, flag_z, flag_c, busy;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_addr(op_addr), .op_data(op_data), .res_valid(res_valid),
    .acc_out(acc_out), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs right after the transfer edge, then check the
  // strobe timing and the committed accumulator/flags.
  task automatic run_op(input string tag, input logic [3:0] opc, input logic [3:0] addr,
                        input logic [7:0] dat, input logic [7:0] e_acc,
                        input logic e_z, input logic e_c);
    int n;
    @(negedge clk);
    opcode = opc; op_addr = addr; op_data = dat; op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) check({tag, ".ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 op_valid = 1'b0; opcode = 4'h8; op_addr = 4'hF; op_data = 8'hA5;
    @(negedge clk);
    check({tag, ".rv_exec"}, res_valid, 1'b0);
    check({tag, ".busy_exec"}, busy, 1'b1);
    @(negedge clk);
    check({tag, ".rv_wb"}, res_valid, 1'b1);
    check({tag, ".acc"}, acc_out, e_acc);
    check({tag, ".z"}, flag_z, e_z);
    check({tag, ".c"}, flag_c, e_c);
    @(negedge clk);
    check({tag, ".rv_idle"}, res_valid, 1'b0);
    check({tag, ".busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; op_valid = 1'b0;
    opcode = '0; op_addr = '0; op_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.acc", acc_out, 8'h00);
    check("rst.z", flag_z, 1'b0);
    check("rst.c", flag_c, 1'b0);
    check("rst.rv", res_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.ready", op_ready, 1'b1);

    run_op("ldi_f0", 4'h4, 4'h0, 8'hF0, 8'hF0, 1'b0, 1'b0);
    run_op("add_20", 4'h0, 4'h0, 8'h20, 8'h10, 1'b0, 1'b1);
    run_op("ldi_01", 4'h4, 4'h0, 8'h01, 8'h01, 1'b0, 1'b0);
    run_op("sub_01a", 4'h1, 4'h0, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("sub_01b", 4'h1, 4'h0, 8'h01, 8'hFF, 1'b0, 1'b1);

    run_op("ldi_3c", 4'h4, 4'h0, 8'h3C, 8'h3C, 1'b0, 1'b0);
    run_op("and_0f", 4'h5, 4'h0, 8'h0F, 8'h0C, 1'b0, 1'b0);
    run_op("or_30", 4'h6, 4'h0, 8'h30, 8'h3C, 1'b0, 1'b0);
    run_op("xor_ff", 4'h7, 4'h0, 8'hFF, 8'hC3, 1'b0, 1'b0);
    run_op("not", 4'h8, 4'h0, 8'h00, 8'h3C, 1'b0, 1'b0);
    run_op("shr_3c", 4'hA, 4'h0, 8'h00, 8'h1E, 1'b0, 1'b0);
    run_op("ldi_01s", 4'h4, 4'h0, 8'h01, 8'h01, 1'b0, 1'b0);
    run_op("shr_01", 4'hA, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1);

    run_op("ldi_05", 4'h4, 4'h0, 8'h05, 8'h05, 1'b0, 1'b0);
    run_op("store_3", 4'h2, 4'h3, 8'h00, 8'h05, 1'b0, 1'b0);
    run_op("ldi_00", 4'h4, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("load_3", 4'h3, 4'h3, 8'h00, 8'h05, 1'b0, 1'b0);
    run_op("addm_3", 4'hB, 4'h3, 8'h00, 8'h0A, 1'b0, 1'b0);
    run_op("load_15", 4'h3, 4'hF, 8'h77, 8'h00, 1'b1, 1'b0);

    // ena low: no transfer even with a pending request
    @(negedge clk);
    ena = 1'b0; opcode = 4'h4; op_data = 8'h99; op_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ena0.ready", op_ready, 1'b0);
    check("ena0.busy", busy, 1'b0);
    check("ena0.acc", acc_out, 8'h00);
    op_valid = 1'b0; ena = 1'b1;

    // op_valid held across a busy op: second op transfers on the first IDLE cycle
    @(negedge clk);
    opcode = 4'h4; op_addr = 4'h0; op_data = 8'h11; op_valid = 1'b1;
    @(posedge clk);
    #1 opcode = 4'h0; op_data = 8'h01;
    @(negedge clk);
    check("hold.ready_exec", op_ready, 1'b0);
    check("hold.rv_exec", res_valid, 1'b0);
    @(negedge clk);
    check("hold.ready_wb", op_ready, 1'b0);
    check("hold.rv_wb", res_valid, 1'b1);
    check("hold.acc1", acc_out, 8'h11);
    @(negedge clk);
    check("hold.ready_idle", op_ready, 1'b1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    check("hold.rv2_exec", res_valid, 1'b0);
    @(negedge clk);
    check("hold.rv2_wb", res_valid, 1'b1);
    check("hold.acc2", acc_out, 8'h12);
    @(negedge clk);
    check("hold.rv2_idle", res_valid, 1'b0);

    // reset while a STORE is in EXEC must not write memory
    run_op("ldi_55", 4'h4, 4'h0, 8'h55, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    opcode = 4'h2; op_addr = 4'h7; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    check("rstx.busy_exec", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstx.acc", acc_out, 8'h00);
    check("rstx.busy", busy, 1'b0);
    check("rstx.rv", res_valid, 1'b0);
    rst_n = 1'b1;
    run_op("ldi_aa", 4'h4, 4'h0, 8'hAA, 8'hAA, 1'b0, 1'b0);
    run_op("load_7", 4'h3, 4'h7, 8'h00, 8'h00, 1'b1, 1'b0);

    // opcode C: ROL when enabled, NOP otherwise; opcode E is always a NOP
    run_op("ldi_81", 4'h4, 4'h0, 8'h81, 8'h81, 1'b0, 1'b0);
`ifdef ACC_CPU_ROTATE_EN
    run_op("op_c", 4'hC, 4'h0, 8'h00, 8'h03, 1'b0, 1'b1);
    run_op("op_d", 4'hD, 4'h0, 8'h00, 8'h81, 1'b0, 1'b1);
`else
    run_op("op_c", 4'hC, 4'h0, 8'h00, 8'h81, 1'b0, 1'b0);
    run_op("op_d", 4'hD, 4'h0, 8'h00, 8'h81, 1'b0, 1'b0);
`endif
    run_op("ldi_81b", 4'h4, 4'h0, 8'h81, 8'h81, 1'b0, 1'b0);
    run_op("shl_81", 4'h9, 4'h0, 8'h00, 8'h02, 1'b0, 1'b1);
    run_op("op_e", 4'hE, 4'h0, 8'hFF, 8'h02, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
